// File: rtl/dmem_bridge_pkg.sv
// -----------------------------------------------------------------------------
// dmem_bridge_pkg
//   Shared definitions for the core data-memory to system-bus bridge:
//   the bridge state encoding, default geometry and timeout, and the byte
//   strobe width helper.
// -----------------------------------------------------------------------------
package dmem_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_R,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int unsigned DEFAULT_ADDR_W  = 32;
    localparam int unsigned DEFAULT_DATA_W  = 32;
    localparam int unsigned DEFAULT_TIMEOUT = 255;
    localparam int unsigned DEFAULT_STRB_W  = DEFAULT_DATA_W / 8;

    // One byte strobe per byte lane of the data bus.
    function automatic int unsigned strb_width(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dmem_bus_bridge.sv
// -----------------------------------------------------------------------------
// dmem_bus_bridge
//   Registers one core data-memory access (load or store) and issues it as a
//   single valid/ready bus transaction, stalling the core until the bus
//   completes, errors out, or the timeout expires. At most one transaction is
//   outstanding.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   core_load/store   access strobes from the core (store wins if both)
//   core_addr         byte address; bus address is word aligned
//   core_wdata/wmask  lane-aligned store data and byte mask
//   core_rdata        raw load word (valid in DONE, 0 in ERR, else held)
//   core_stall        core holds PC while high (combinational)
//   core_fault        one-cycle pulse on bus error or timeout
//   bus_valid/ready   request handshake
//   bus_we/addr/wdata/wstrb  request fields, stable while bus_valid is high
//   bus_rvalid/rdata  read response
//   bus_err           error, qualified by bus_ready (write) or bus_rvalid (read)
// -----------------------------------------------------------------------------
module dmem_bus_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W  = DEFAULT_DATA_W,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          core_load,
    input  logic                          core_store,
    input  logic [ADDR_W-1:0]             core_addr,
    input  logic [DATA_W-1:0]             core_wdata,
    input  logic [strb_width(DATA_W)-1:0] core_wmask,
    output logic [DATA_W-1:0]             core_rdata,
    output logic                          core_stall,
    output logic                          core_fault,
    output logic                          bus_valid,
    input  logic                          bus_ready,
    output logic                          bus_we,
    output logic [ADDR_W-1:0]             bus_addr,
    output logic [DATA_W-1:0]             bus_wdata,
    output logic [strb_width(DATA_W)-1:0] bus_wstrb,
    input  logic                          bus_rvalid,
    input  logic [DATA_W-1:0]             bus_rdata,
    input  logic                          bus_err
);

    localparam int unsigned STRB_W = strb_width(DATA_W);
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_bus_valid;
    logic                r_bus_we;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [DATA_W-1:0]   r_bus_wdata;
    logic [STRB_W-1:0]   r_bus_wstrb;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_fault;

    logic                w_access;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                w_timeout;

    assign w_access   = core_load | core_store;
    assign w_cnt_next = r_cnt + CNT_W'(1);
    // Counter starts at 0 on entry to REQ, so this fires on the TIMEOUT-th
    // cycle spent in REQ/WAIT_R.
    assign w_timeout  = (w_cnt_next == CNT_W'(TIMEOUT));

    always_comb begin
        core_stall = 1'b0;
        case (r_state)
            ST_IDLE:   core_stall = w_access;
            ST_REQ:    core_stall = 1'b1;
            ST_WAIT_R: core_stall = 1'b1;
            default:   core_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bus_valid <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wstrb <= '0;
            r_rdata     <= '0;
            r_fault     <= 1'b0;
        end else begin
            r_fault <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_access) begin
                        // Masking instead of slicing keeps every address bit
                        // in use while forcing word alignment.
                        r_bus_addr  <= core_addr & ~ADDR_W'(3);
                        r_bus_we    <= core_store;
                        r_bus_wdata <= core_wdata;
                        r_bus_wstrb <= core_store ? core_wmask : '0;
                        r_cnt       <= '0;
                        r_bus_valid <= 1'b1;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    r_cnt <= w_cnt_next;
                    if (bus_ready && (r_bus_we || bus_rvalid)) begin
                        r_bus_valid <= 1'b0;
                        if (bus_err) begin
                            // Read data captured with an error is replaced
                            // by 0, which is what ERR presents anyway.
                            r_rdata <= '0;
                            r_fault <= 1'b1;
                            r_state <= ST_ERR;
                        end else begin
                            if (!r_bus_we) begin
                                r_rdata <= bus_rdata;
                            end
                            r_state <= ST_DONE;
                        end
                    end else if (w_timeout) begin
                        r_bus_valid <= 1'b0;
                        r_rdata     <= '0;
                        r_fault     <= 1'b1;
                        r_state     <= ST_ERR;
                    end else if (bus_ready) begin
                        r_bus_valid <= 1'b0;
                        r_state     <= ST_WAIT_R;
                    end
                end
                ST_WAIT_R: begin
                    r_cnt <= w_cnt_next;
                    if (bus_rvalid) begin
                        if (bus_err) begin
                            r_rdata <= '0;
                            r_fault <= 1'b1;
                            r_state <= ST_ERR;
                        end else begin
                            r_rdata <= bus_rdata;
                            r_state <= ST_DONE;
                        end
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_fault <= 1'b1;
                        r_state <= ST_ERR;
                    end
                end
                // The core retires in DONE/ERR; its strobes may still be
                // high there, so a new request only starts from IDLE.
                ST_DONE: r_state <= ST_IDLE;
                ST_ERR:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus_valid  = r_bus_valid;
    assign bus_we     = r_bus_we;
    assign bus_addr   = r_bus_addr;
    assign bus_wdata  = r_bus_wdata;
    assign bus_wstrb  = r_bus_wstrb;
    assign core_rdata = r_rdata;
    assign core_fault = r_fault;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_dmem_bus_bridge
//   Directed bench for dmem_bus_bridge (TIMEOUT overridden to 4). The driver
//   pushes the expected bus request and the expected core retirement for each
//   access; an independent monitor compares them when the DUT presents a
//   request or the core stall falls.
// -----------------------------------------------------------------------------
module tb_dmem_bus_bridge;
    import dmem_bridge_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DEFAULT_STRB_W;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_load, core_store;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic [SW-1:0] core_wmask;
    logic [DW-1:0] core_rdata;
    logic          core_stall, core_fault;
    logic          bus_valid, bus_ready, bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [SW-1:0] bus_wstrb;
    logic          bus_rvalid;
    logic [DW-1:0] bus_rdata;
    logic          bus_err;

    dmem_bus_bridge #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .core_load (core_load),
        .core_store(core_store),
        .core_addr (core_addr),
        .core_wdata(core_wdata),
        .core_wmask(core_wmask),
        .core_rdata(core_rdata),
        .core_stall(core_stall),
        .core_fault(core_fault),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wstrb (bus_wstrb),
        .bus_rvalid(bus_rvalid),
        .bus_rdata (bus_rdata),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } req_t;

    typedef struct {
        logic          fault;
        logic [DW-1:0] rdata;
        int unsigned   stalls;
    } ret_t;

    req_t req_q[$];
    ret_t ret_q[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit          m_prev_stall = 1'b0;
    bit          m_in_req     = 1'b0;
    int unsigned m_stall_cnt  = 0;
    req_t        m_er;
    ret_t        m_et;

    always @(negedge clk) begin
        if (!reset) begin
            m_prev_stall = 1'b0;
            m_in_req     = 1'b0;
            m_stall_cnt  = 0;
        end else begin
            if (bus_valid) begin
                n_tests++;
                if (req_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bus_req: unexpected request addr=%h we=%b", bus_addr, bus_we);
                end else begin
                    m_er = req_q[0];
                    if (bus_we !== m_er.we || bus_addr !== m_er.addr ||
                        bus_wdata !== m_er.wdata || bus_wstrb !== m_er.wstrb) begin
                        n_fail++;
                        $display("FAIL bus_req: got we=%b addr=%h wdata=%h wstrb=%b expected we=%b addr=%h wdata=%h wstrb=%b",
                                 bus_we, bus_addr, bus_wdata, bus_wstrb,
                                 m_er.we, m_er.addr, m_er.wdata, m_er.wstrb);
                    end
                    if (bus_ready) begin
                        void'(req_q.pop_front());
                        m_in_req = 1'b0;
                    end else begin
                        m_in_req = 1'b1;
                    end
                end
            end else if (m_in_req) begin
                // Request withdrawn without a handshake (timeout).
                void'(req_q.pop_front());
                m_in_req = 1'b0;
            end

            if (core_stall) begin
                m_stall_cnt++;
            end else if (m_prev_stall) begin
                n_tests++;
                if (ret_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL retire: unexpected retire fault=%b rdata=%h", core_fault, core_rdata);
                end else begin
                    m_et = ret_q.pop_front();
                    if (core_fault !== m_et.fault || core_rdata !== m_et.rdata ||
                        m_stall_cnt != m_et.stalls) begin
                        n_fail++;
                        $display("FAIL retire: got fault=%b rdata=%h stalls=%0d expected fault=%b rdata=%h stalls=%0d",
                                 core_fault, core_rdata, m_stall_cnt,
                                 m_et.fault, m_et.rdata, m_et.stalls);
                    end
                end
                m_stall_cnt = 0;
            end else if (core_fault !== 1'b0) begin
                n_tests++;
                n_fail++;
                $display("FAIL fault_pulse: got %b outside retire expected 0", core_fault);
            end
            m_prev_stall = core_stall;
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bus(input int k, input int rdy_k, input int rv_k,
                             input int err_k, input logic [DW-1:0] rd);
        bus_ready  = (k == rdy_k);
        bus_rvalid = (k == rv_k);
        bus_err    = (k == err_k);
        bus_rdata  = (k == rv_k) ? rd : '0;
    endtask

    // Cycle k=0 is the IDLE cycle in which the core presents the access.
    task automatic access(input bit ld, input bit st, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input logic [SW-1:0] mask,
                          input int rdy_k, input int rv_k, input int err_k,
                          input logic [DW-1:0] rd,
                          input logic e_we, input logic [AW-1:0] e_addr,
                          input logic [SW-1:0] e_wstrb, input logic e_fault,
                          input logic [DW-1:0] e_rdata, input int unsigned e_stalls);
        int  k;
        bit  done;
        req_q.push_back('{we: e_we, addr: e_addr, wdata: wd, wstrb: e_wstrb});
        ret_q.push_back('{fault: e_fault, rdata: e_rdata, stalls: e_stalls});
        core_load  = ld;
        core_store = st;
        core_addr  = addr;
        core_wdata = wd;
        core_wmask = mask;
        k    = 0;
        done = 1'b0;
        drive_bus(k, rdy_k, rv_k, err_k, rd);
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            k++;
            if (!core_stall) begin
                done = 1'b1;
            end else begin
                drive_bus(k, rdy_k, rv_k, err_k, rd);
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL access_timeout: stall still %b after 40 cycles expected 0", core_stall);
        end
        chk("valid_low_at_retire", {63'd0, bus_valid}, 64'd0);
        core_load  = 1'b0;
        core_store = 1'b0;
        drive_bus(-2, -1, -1, -1, '0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        core_load  = 1'b0;
        core_store = 1'b0;
        core_addr  = '0;
        core_wdata = '0;
        core_wmask = '0;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
        bus_err    = 1'b0;
        step();
        chk("rst_valid", {63'd0, bus_valid}, 64'd0);
        chk("rst_we",    {63'd0, bus_we}, 64'd0);
        chk("rst_addr",  {32'd0, bus_addr}, 64'd0);
        chk("rst_wdata", {32'd0, bus_wdata}, 64'd0);
        chk("rst_wstrb", {60'd0, bus_wstrb}, 64'd0);
        chk("rst_rdata", {32'd0, core_rdata}, 64'd0);
        chk("rst_fault", {63'd0, core_fault}, 64'd0);
        chk("rst_stall", {63'd0, core_stall}, 64'd0);
        step();
        reset = 1'b1;
        step();

        // ld st addr wdata mask rdy rv err rd | we addr wstrb fault rdata stalls
        access(0, 1, 32'h102, 32'hDEADBEEF, 4'b0100, 1, -1, -1, 32'h0,
               1, 32'h100, 4'b0100, 0, 32'h0, 2);
        access(1, 0, 32'h200, 32'h0, 4'b1111, 1, 3, -1, 32'h12345678,
               0, 32'h200, 4'b0000, 0, 32'h12345678, 4);
        access(0, 1, 32'h0FC, 32'h00C0FFEE, 4'b1111, 1, -1, -1, 32'h0,
               1, 32'h0FC, 4'b1111, 0, 32'h12345678, 2);
        // Ready withheld for 3 cycles; handshake lands on the last cycle
        // before the 4-cycle timeout and must still complete.
        access(1, 0, 32'h307, 32'h00000055, 4'b0000, 4, 4, -1, 32'hA5A55A5A,
               0, 32'h304, 4'b0000, 0, 32'hA5A55A5A, 5);
        access(1, 0, 32'h020, 32'h0, 4'b0000, 1, 2, 2, 32'hFFFF0000,
               0, 32'h020, 4'b0000, 1, 32'h0, 3);
        access(1, 1, 32'h00B, 32'h11112222, 4'b0011, 1, -1, -1, 32'h0,
               1, 32'h008, 4'b0011, 0, 32'h0, 2);
        access(1, 0, 32'h010, 32'h0, 4'b0000, 1, 1, -1, 32'h0BADF00D,
               0, 32'h010, 4'b0000, 0, 32'h0BADF00D, 2);
        access(0, 1, 32'h044, 32'hCAFEBABE, 4'b1000, 1, -1, 1, 32'h0,
               1, 32'h044, 4'b1000, 1, 32'h0, 2);
        access(1, 0, 32'h014, 32'h0, 4'b0000, 1, 1, -1, 32'h600DCAFE,
               0, 32'h014, 4'b0000, 0, 32'h600DCAFE, 2);
        // Timeout in WAIT_R: accepted read never answered.
        access(1, 0, 32'h048, 32'h0, 4'b0000, 1, -1, -1, 32'h0,
               0, 32'h048, 4'b0000, 1, 32'h0, 5);
        access(1, 0, 32'h018, 32'h0, 4'b0000, 1, 1, -1, 32'h24681357,
               0, 32'h018, 4'b0000, 0, 32'h24681357, 2);
        // Timeout in REQ: ready never asserted.
        access(1, 0, 32'h400, 32'h0, 4'b0000, -1, -1, -1, 32'h0,
               0, 32'h400, 4'b0000, 1, 32'h0, 5);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hBAD0BAD0;
        step();
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
        step();
        chk("spurious_rvalid_rdata", {32'd0, core_rdata}, 64'd0);
        chk("spurious_rvalid_stall", {63'd0, core_stall}, 64'd0);

        // Reset while waiting for read data.
        access(1, 0, 32'h01C, 32'h0, 4'b0000, 1, 1, -1, 32'h13579BDF,
               0, 32'h01C, 4'b0000, 0, 32'h13579BDF, 2);
        req_q.push_back('{we: 1'b0, addr: 32'h500, wdata: 32'h0, wstrb: 4'b0000});
        core_load = 1'b1;
        core_addr = 32'h500;
        core_wdata = '0;
        core_wmask = '0;
        step();
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        chk("pre_reset_stall", {63'd0, core_stall}, 64'd1);
        reset     = 1'b0;
        core_load = 1'b0;
        #1;
        chk("async_rst_valid", {63'd0, bus_valid}, 64'd0);
        chk("async_rst_stall", {63'd0, core_stall}, 64'd0);
        chk("async_rst_rdata", {32'd0, core_rdata}, 64'd0);
        step();
        step();
        reset      = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hDEADDEAD;
        step();
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
        chk("stale_rvalid_rdata", {32'd0, core_rdata}, 64'd0);
        access(0, 1, 32'h600, 32'h87654321, 4'b1111, 1, 1, -1, 32'hFFFFFFFF,
               1, 32'h600, 4'b1111, 0, 32'h0, 2);

        step();
        step();
        chk("req_queue_drained", 64'(req_q.size()), 64'd0);
        chk("ret_queue_drained", 64'(ret_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_bus_bridge.md
Name: dmem_bus_bridge

Overview:
- Sits between the single-cycle core's data-memory port and a valid/ready system bus. The core's port carries the ALU address, aligned write data, byte write mask and load/store strobes.
- Registers each core access and issues it as one bus transaction.
- Stalls the core until the transaction completes, then returns read data or a fault.
- Lets the core run against variable-latency memory or peripherals instead of a zero-wait-state RAM.

Parameters:
- ADDR_W, 32, core/bus address width
- DATA_W, 32, data width; byte strobe width is DATA_W/8
- TIMEOUT, 255, max cycles in REQ+WAIT_R before fault; counter width $clog2(TIMEOUT+1)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- core_load  in  1  current instruction is a load
- core_store  in  1  current instruction is a store
- core_addr  in  ADDR_W  byte address (ALU result)
- core_wdata  in  DATA_W  lane-aligned store data
- core_wmask  in  DATA_W/8  byte write mask
- core_rdata  out  DATA_W  raw load word to the core's load extractor
- core_stall  out  1  core holds PC and suppresses register write while high
- core_fault  out  1  one-cycle pulse: bus error or timeout
- bus_valid  out  1  request valid
- bus_ready  in  1  request accepted
- bus_we  out  1  1=write, 0=read
- bus_addr  out  ADDR_W  request address, low 2 bits forced 0
- bus_wdata  out  DATA_W  write data
- bus_wstrb  out  DATA_W/8  byte strobes; 0 on reads
- bus_rvalid  in  1  read response valid
- bus_rdata  in  DATA_W  read response data
- bus_err  in  1  error, qualified by bus_ready (write) or bus_rvalid (read)

Behaviour:
- Reset (async, low): state=IDLE, bus_valid=0, bus_we=0, bus_addr/wdata/wstrb=0, core_rdata=0, core_fault=0, timeout counter=0. Mid-transaction reset drops bus_valid immediately. The transaction is abandoned; any later bus response is ignored.
- States: IDLE, REQ, WAIT_R, DONE, ERR.
- core_stall = (IDLE & (core_load|core_store)) | REQ | WAIT_R. This is combinational, so the core stalls in the same cycle it presents an access.
- IDLE: on load|store, capture the request:
  - bus_addr = {core_addr[ADDR_W-1:2], 2'b00}
  - bus_we = core_store
  - bus_wdata = core_wdata
  - bus_wstrb = core_store ? core_wmask : 0
  - clear the counter; go to REQ
  - If load and store are both high: store wins (illegal input, defined anyway).
- REQ: bus_valid=1; all bus request fields are held stable until the handshake.
  - bus_ready & bus_we & !bus_err -> DONE
  - bus_ready & bus_we & bus_err -> ERR
  - bus_ready & !bus_we & bus_rvalid in the same cycle -> capture bus_rdata; go to DONE, or ERR if bus_err
  - bus_ready & !bus_we otherwise -> WAIT_R
- WAIT_R: bus_valid=0. On bus_rvalid, capture core_rdata=bus_rdata, then go to ERR if bus_err, else DONE.
- Timeout: the counter increments every cycle in REQ or WAIT_R. When it reaches TIMEOUT without completion -> ERR and bus_valid drops.
- DONE: stall=0 for one cycle and core_rdata is valid; the core retires the instruction at this edge. Next state is always IDLE; the still-asserted strobe in DONE does not start a new request.
- ERR: stall=0, core_fault=1 for one cycle, core_rdata=0. Next state IDLE.
- core_rdata holds its last value outside DONE/ERR.
- Minimum latency with a zero-wait bus:
  - store: 2 stall cycles (IDLE, REQ), retire in the 3rd cycle
  - load with rvalid together with ready: same as store
  - load with rvalid one cycle after ready: 3 stall cycles
- No pipelining: at most one outstanding transaction.

Decomposition:
- Shared package dmem_bridge_pkg:
  - state enum (IDLE, REQ, WAIT_R, DONE, ERR)
  - default TIMEOUT constant
  - strobe-width localparam
- No sub-module required. The timeout counter stays inline; no separate watchdog_counter.

Test Plan:
- Store 0xDEADBEEF, mask 4'b0100, addr 0x102, bus_ready=1 immediately -> bus_addr=0x100, bus_wstrb=0100, bus_we=1, stall high 2 cycles, no fault.
- Load addr 0x200, ready in cycle 1, rvalid with 0x12345678 two cycles later -> stall 4 cycles, core_rdata=0x12345678 in DONE, bus_wstrb=0.
- Load, bus_ready held low 3 cycles -> bus_valid, bus_addr, bus_we and bus_wstrb stable throughout, handshake completes normally.
- Load with rvalid and bus_err together -> core_fault one-cycle pulse, core_rdata=0, stall drops, return to IDLE.
- TIMEOUT=4, bus_ready never asserted -> ERR 4 cycles after entering REQ, bus_valid drops, fault pulse; a later spurious rvalid is ignored.
- Assert reset during WAIT_R -> bus_valid, core_stall and core_rdata go to 0 asynchronously. After release, a new store completes normally and ignores the stale rvalid.
